// File: rtl/busca_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   estado_t    : fetch FSM states (OCIOSO, BUSCA, CHEIO, ERRO)
//   OPCODE_*    : bit positions of the opcode inside the instruction word
//   JUMP_W      : width of the absolute jump target field
//   BRANCH_W    : width of the branch displacement field
package busca_pkg;

  localparam int INSTR_W    = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 27;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;
  localparam int JUMP_W     = 27;
  localparam int BRANCH_W   = 17;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    BUSCA  = 2'd1,
    CHEIO  = 2'd2,
    ERRO   = 2'd3
  } estado_t;

endpackage

// File: rtl/decodificador_campos.sv
// Splits an instruction word into the fields the control unit uses.
// Purely combinational; fields are raw slices, no sign extension.
//   instrucao          in  : instruction word
//   opcode             out : instrucao[31:27]
//   enderecoJump       out : instrucao[26:0]
//   deslocamentoBranch out : instrucao[16:0]
module decodificador_campos
  import busca_pkg::*;
(
  input  logic [INSTR_W-1:0]  instrucao,
  output logic [OPCODE_W-1:0] opcode,
  output logic [JUMP_W-1:0]   enderecoJump,
  output logic [BRANCH_W-1:0] deslocamentoBranch
);

  assign opcode             = instrucao[OPCODE_MSB:OPCODE_LSB];
  assign enderecoJump       = instrucao[JUMP_W-1:0];
  assign deslocamentoBranch = instrucao[BRANCH_W-1:0];

endmodule

// File: rtl/unidade_busca_instrucao.sv
// Instruction-fetch stage downstream of the program counter.
// Issues one outstanding read per PC value, holds the returned word in an
// instruction register and hands it to the control unit over valid/ready.
// stall_pc stays high until the instruction is consumed, so the PC advances
// exactly once per delivered instruction.
//
// Ports:
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   pc                  : current program counter
//   flush               : drop the current or in-flight instruction
//   mem_req/mem_addr    : read request to instruction memory (held until ack)
//   mem_ack/mem_data    : one-cycle data return from memory
//   instr_valid/ready   : handshake towards the control unit
//   instrucao + fields  : instruction register and its decoded slices
//   stall_pc            : high while the PC must hold
//   erro_busca          : sticky flag, memory did not answer within TIMEOUT
//   contador_instr      : consumed-instruction count (only with FETCH_COUNT_EN)
//
// Build option: define FETCH_COUNT_EN to add the contador_instr output.
module unidade_busca_instrucao
  import busca_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         pc,
  input  logic                flush,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_ack,
  input  logic [31:0]         mem_data,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [31:0]         instrucao,
  output logic [OPCODE_W-1:0] opcode,
  output logic [JUMP_W-1:0]   enderecoJump,
  output logic [BRANCH_W-1:0] deslocamentoBranch,
  output logic                stall_pc,
  output logic                erro_busca
`ifdef FETCH_COUNT_EN
  ,
  output logic [31:0]         contador_instr
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] ULTIMO_CICLO = CNT_W'(TIMEOUT - 1);

  estado_t          estado;
  logic [CNT_W-1:0] contadorTimeout;
  // Set when a flush hits while the read is still in flight: the request
  // cannot be withdrawn, so its data is swallowed when the ack arrives.
  logic             descarte;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado          <= OCIOSO;
      mem_req         <= 1'b0;
      mem_addr        <= '0;
      instr_valid     <= 1'b0;
      instrucao       <= '0;
      erro_busca      <= 1'b0;
      contadorTimeout <= '0;
      descarte        <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          mem_addr        <= pc[ADDR_W-1:0];
          mem_req         <= 1'b1;
          contadorTimeout <= '0;
          estado          <= BUSCA;
        end

        BUSCA: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            // A flush arriving together with the ack also kills this word.
            if (descarte || flush) begin
              descarte <= 1'b0;
              estado   <= OCIOSO;
            end else begin
              instrucao   <= mem_data;
              instr_valid <= 1'b1;
              estado      <= CHEIO;
            end
          end else if (contadorTimeout == ULTIMO_CICLO) begin
            mem_req    <= 1'b0;
            erro_busca <= 1'b1;
            descarte   <= 1'b0;
            estado     <= ERRO;
          end else begin
            contadorTimeout <= contadorTimeout + CNT_W'(1);
            if (flush) begin
              descarte <= 1'b1;
            end
          end
        end

        CHEIO: begin
          // flush wins over a same-cycle instr_ready; both leave to OCIOSO.
          if (flush || instr_ready) begin
            instr_valid <= 1'b0;
            estado      <= OCIOSO;
          end
        end

        ERRO: begin
          mem_req     <= 1'b0;
          instr_valid <= 1'b0;
          erro_busca  <= 1'b1;
        end

        default: estado <= OCIOSO;
      endcase
    end
  end

  assign stall_pc = reset | ~(instr_valid & instr_ready);

`ifdef FETCH_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contador_instr <= '0;
    end else if (instr_valid && instr_ready && !flush) begin
      contador_instr <= contador_instr + 32'd1;
    end
  end
`endif

  decodificador_campos u_decodificador (
    .instrucao          (instrucao),
    .opcode             (opcode),
    .enderecoJump       (enderecoJump),
    .deslocamentoBranch (deslocamentoBranch)
  );

endmodule

// File: tb/tb_unidade_busca_instrucao.sv
// Randomized bench for unidade_busca_instrucao. A memory model answers each
// request after a random delay with a word derived from the address; a
// transaction-level scoreboard checks request addresses, delivered words,
// flush discards, handshake behaviour, stall_pc, timeout and reset.
module tb_unidade_busca_instrucao;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        flush;
  logic        mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instrucao;
  logic [4:0]  opcode;
  logic [26:0] enderecoJump;
  logic [16:0] deslocamentoBranch;
  logic        stall_pc;
  logic        erro_busca;
`ifdef FETCH_COUNT_EN
  logic [31:0] contador_instr;
`endif

  int compared   = 0;
  int mismatched = 0;

  // Scoreboard / memory-model state
  logic [31:0] reqAddr;
  bit          pendFlushed;
  int          delayLeft;
  int          minDelay, maxDelay;
  int          consumed;
  bit          flushAllowed;
  int          readyPct;

  always #5 clock = ~clock;

  unidade_busca_instrucao #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clock              (clock),
    .reset              (reset),
    .pc                 (pc),
    .flush              (flush),
    .mem_req            (mem_req),
    .mem_addr           (mem_addr),
    .mem_ack            (mem_ack),
    .mem_data           (mem_data),
    .instr_valid        (instr_valid),
    .instr_ready        (instr_ready),
    .instrucao          (instrucao),
    .opcode             (opcode),
    .enderecoJump       (enderecoJump),
    .deslocamentoBranch (deslocamentoBranch),
    .stall_pc           (stall_pc),
    .erro_busca         (erro_busca)
`ifdef FETCH_COUNT_EN
    ,
    .contador_instr     (contador_instr)
`endif
  );

  task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory contents: address 0 holds 32'h0800_0005 (opcode 1, jump 5).
  function automatic logic [31:0] palavra(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0800_0005;
  endfunction

  task automatic confere_reset_vals(input string tag);
    confere({tag, "_req"},   32'(mem_req), 32'd0);
    confere({tag, "_addr"},  32'(mem_addr), 32'd0);
    confere({tag, "_valid"}, 32'(instr_valid), 32'd0);
    confere({tag, "_instr"}, instrucao, 32'd0);
    confere({tag, "_erro"},  32'(erro_busca), 32'd0);
    confere({tag, "_stall"}, 32'(stall_pc), 32'd1);
  endtask

  task automatic aplica_reset();
    @(posedge clock); #1;
    reset = 1'b1; mem_ack = 1'b0; flush = 1'b0; instr_ready = 1'b1;
    #1 confere_reset_vals("reset_async");
    @(posedge clock); #1;
    confere_reset_vals("reset_held");
    consumed = 0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // One clock cycle: capture what the coming edge sees, check the outcome
  // against the transaction rules, then drive the next inputs.
  task automatic ciclo();
    logic        eAck, eFlush, eReady, eValid, eReq;
    logic [31:0] ePc, eInstr, eAddr, w;
    eAck = mem_ack; eFlush = flush; eReady = instr_ready; eValid = instr_valid;
    eReq = mem_req; ePc = pc; eInstr = instrucao; eAddr = mem_addr;

    @(posedge clock); #1;

    if (!eReq && mem_req) begin
      confere("addr_do_pc", mem_addr, ePc);
      reqAddr     = mem_addr;
      pendFlushed = 1'b0;
      delayLeft   = $urandom_range(maxDelay, minDelay);
    end
    if (eReq && !eAck) begin
      confere("req_mantido", 32'(mem_req), 32'd1);
      confere("addr_estavel", mem_addr, eAddr);
      if (eFlush) pendFlushed = 1'b1;
    end
    if (eReq && eAck) begin
      confere("req_cai_ack", 32'(mem_req), 32'd0);
      if (eFlush || pendFlushed) begin
        confere("descarte_valid", 32'(instr_valid), 32'd0);
      end else begin
        w = palavra(reqAddr);
        confere("valid_apos_ack", 32'(instr_valid), 32'd1);
        confere("instrucao", instrucao, w);
        confere("opcode", 32'(opcode), w >> 27);
        confere("jump", 32'(enderecoJump), w & 32'h07FF_FFFF);
        confere("branch", 32'(deslocamentoBranch), w & 32'h0001_FFFF);
      end
    end
    if (eValid) begin
      if (eFlush || eReady) begin
        confere("valid_cai", 32'(instr_valid), 32'd0);
        if (!eFlush) begin
          consumed++;
          pc = pc + 32'd4;
        end
      end else begin
        confere("valid_mantido", 32'(instr_valid), 32'd1);
        confere("instr_estavel", instrucao, eInstr);
      end
    end else if (!(eReq && eAck)) begin
      confere("sem_valid_espurio", 32'(instr_valid), 32'd0);
    end
    if (eFlush) pc = $urandom() & 32'hFFFF_FFFC;
    confere("sem_erro", 32'(erro_busca), 32'd0);

    // Next inputs
    flush       = flushAllowed && (mem_req || instr_valid) && ($urandom_range(9, 0) == 0);
    instr_ready = ($urandom_range(99, 0) < readyPct);
    mem_ack     = 1'b0;
    mem_data    = $urandom();
    if (mem_req) begin
      if (delayLeft == 0) begin
        mem_ack  = 1'b1;
        mem_data = palavra(mem_addr);
      end else begin
        delayLeft--;
      end
    end
    #1 confere("stall_pc", 32'(stall_pc), 32'(!(instr_valid && instr_ready)));
  endtask

  initial begin
    int n;
    reset = 1'b1; pc = 32'd0; flush = 1'b0; mem_ack = 1'b0; mem_data = 32'd0;
    instr_ready = 1'b0; minDelay = 0; maxDelay = 0; flushAllowed = 1'b0;
    readyPct = 100; delayLeft = 0; pendFlushed = 1'b0; reqAddr = 32'd0; consumed = 0;
    aplica_reset();

    // Basic fetch from pc=0, immediate ack, consumer always ready
    pc = 32'd0; minDelay = 0; maxDelay = 0; readyPct = 100;
    repeat (12) ciclo();

    // Slow memory with back-pressure
    minDelay = 5; maxDelay = 5; readyPct = 30;
    repeat (40) ciclo();

    // Random delays, flushes and back-pressure
    minDelay = 0; maxDelay = 6; readyPct = 50; flushAllowed = 1'b1;
    repeat (600) ciclo();

`ifdef FETCH_COUNT_EN
    confere("contador_instr", contador_instr, 32'(consumed));
`endif

    // Reset mid-fetch, then a stray ack right after release
    flushAllowed = 1'b0; minDelay = 3; maxDelay = 3;
    n = 0;
    while (!mem_req && n < 10) begin ciclo(); n++; end
    confere("req_antes_reset", 32'(mem_req), 32'd1);
    aplica_reset();
    mem_ack = 1'b1; mem_data = 32'hDEAD_BEEF; pc = 32'h0000_1000;
    minDelay = 0; maxDelay = 4; readyPct = 60; flushAllowed = 1'b1;
    repeat (60) ciclo();

    // Timeout: memory never answers
    aplica_reset();
    pc = 32'h0000_0040; instr_ready = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (erro_busca) break;
      if (mem_req) n++;
    end
    confere("timeout_erro", 32'(erro_busca), 32'd1);
    confere("timeout_ciclos", 32'(n), 32'(TIMEOUT));
    confere("timeout_req", 32'(mem_req), 32'd0);
    for (int i = 0; i < 6; i++) begin
      mem_ack = 1'($urandom_range(1, 0)); instr_ready = 1'($urandom_range(1, 0));
      flush = 1'($urandom_range(1, 0)); mem_data = $urandom();
      @(posedge clock); #1;
      confere("erro_pegajoso", 32'(erro_busca), 32'd1);
      confere("erro_req", 32'(mem_req), 32'd0);
      confere("erro_valid", 32'(instr_valid), 32'd0);
    end
    aplica_reset();
    confere("erro_limpo", 32'(erro_busca), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/unidade_busca_instrucao.md
Name: unidade_busca_instrucao

Overview:
Instruction-fetch stage sitting directly downstream of the program counter.
- Takes the current PC and issues a single-outstanding read to instruction memory over a req/ack handshake.
- Latches the returned word into an instruction register and presents it, with its decoded jump/branch fields, to the control unit over a valid/ready handshake.
- Generates the PC stall signal that the control logic turns into a PC hold (controlePC = 3'b111) until the instruction is consumed.

Parameters:
ADDR_W, 32, width of the instruction-memory address driven from pc[ADDR_W-1:0]
TIMEOUT, 16, maximum cycles to wait for mem_ack before flagging a fetch error (min 2)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
pc  in  32  current program counter
flush  in  1  discard current or in-flight instruction (taken jump/branch)
mem_req  out  1  read request to instruction memory
mem_addr  out  ADDR_W  read address
mem_ack  in  1  memory data valid, one-cycle pulse
mem_data  in  32  instruction word, valid with mem_ack
instr_valid  out  1  instruction register holds a deliverable instruction
instr_ready  in  1  consumer accepts the instruction
instrucao  out  32  instruction register
opcode  out  5  instrucao[31:27]
enderecoJump  out  27  instrucao[26:0]
deslocamentoBranch  out  17  instrucao[16:0]
stall_pc  out  1  high = PC must hold
erro_busca  out  1  sticky fetch timeout flag

Behaviour:
Reset values:
- State OCIOSO; mem_req=0, mem_addr=0, instr_valid=0, instrucao=0, erro_busca=0, timeout counter=0, descarte=0.
- stall_pc=1 while reset is asserted and whenever not (instr_valid & instr_ready).

FSM:
- OCIOSO: next cycle goes to BUSCA, latching mem_addr <= pc[ADDR_W-1:0] and mem_req <= 1.
- BUSCA: mem_req held high and mem_addr stable until mem_ack. Counter increments each cycle.
  - On mem_ack with descarte=0: instrucao <= mem_data, instr_valid <= 1, mem_req <= 0, go to CHEIO.
  - On mem_ack with descarte=1: drop the data, clear descarte, go to OCIOSO.
  - Counter reaching TIMEOUT-1 without ack: mem_req <= 0, erro_busca <= 1, go to ERRO.
- CHEIO: instr_valid=1 and instrucao stable. When instr_valid & instr_ready in a cycle, instr_valid <= 0 and go to OCIOSO. In that cycle stall_pc=0, so the PC advances exactly once per consumed instruction.
- ERRO: all outputs idle except erro_busca=1. Exit only through reset.

Latency: minimum 3 cycles from a PC update to instr_valid (OCIOSO, BUSCA with same-cycle ack, CHEIO).

Flush:
- flush in CHEIO: instr_valid <= 0, go to OCIOSO. A same-cycle instr_ready is ignored.
- flush in BUSCA: request cannot be cancelled; set descarte=1 and keep waiting for ack.
- flush in OCIOSO: no effect.

Other rules:
- mem_ack outside BUSCA is ignored.
- Reset asserted mid-fetch returns to OCIOSO immediately. A late mem_ack after reset deassertion is ignored.
- Field outputs are pure slices of instrucao (no sign extension here).

Optional Feature:
FETCH_COUNT_EN:
- Defined: adds output contador_instr[31:0], reset to 0, incremented on every instr_valid & instr_ready handshake with flush low. Wraps from 0xFFFFFFFF to 0.
- Undefined: the port and counter are absent.

Decomposition:
- Package busca_pkg: FSM state encoding (OCIOSO, BUSCA, CHEIO, ERRO); field position constants OPCODE_MSB=31, OPCODE_LSB=27, JUMP_W=27, BRANCH_W=17.
- One natural sub-module: decodificador_campos, purely combinational, splitting instrucao into opcode, enderecoJump and deslocamentoBranch.

Test Plan:
1. Basic fetch: reset, pc=0, memory acks 1 cycle after req with 32'h0800_0005 -> mem_addr=0; instr_valid high with opcode=5'h01, enderecoJump=27'h5; stall_pc low only in the instr_ready cycle.
2. Slow memory: ack after 5 cycles, TIMEOUT=16 -> mem_req held 5 cycles with mem_addr stable; erro_busca stays 0.
3. Timeout: no ack -> after 16 BUSCA cycles erro_busca=1 and mem_req=0; state sticks until reset, then erro_busca=0.
4. Flush in BUSCA: flush pulse, ack of 32'hDEADBEEF 2 cycles later -> instr_valid never rises for it; refetch starts from the new pc.
5. Back-pressure: instr_ready low for 4 cycles in CHEIO -> instrucao stable, stall_pc=1 throughout; one handshake yields exactly one PC advance.
6. FETCH_COUNT_EN: 10 consumed instructions with one flushed -> contador_instr=9.
